// File: rtl/bomb_scheduler.sv
// ============================================================================
// bomb_scheduler
// ----------------------------------------------------------------------------
// Shared bomb-pool scheduler sitting between the two player movement
// controllers and the video renderer.
//
// Each of the NB_BOMBS slots runs its own small sequence:
//    FREE -> FUSE -> EXPL -> FREE
// It advances one step per frame tick, and a frame tick is the rising edge of
// EOF. Player drop requests are arbitrated onto free slots. A drop is refused
// when the tile already holds a live bomb or when no slot is left.
//
// Optional feature (compile-time macro):
//    BOMB_LIMIT_EN  - caps each player at MAX_PER_PLAYER live bombs. A capped
//                     request is refused without consuming a slot and without
//                     blocking the other player.
//
// Ports:
//    clk          system clock
//    reset_n      asynchronous active-low reset
//    EOF          end-of-frame level from video timing
//    req[1:0]     drop request, bit p = player p
//    p0_x/p0_y    player 0 tile coordinates
//    p1_x/p1_y    player 1 tile coordinates
//    gnt[1:0]     one-cycle pulse: drop accepted for player p
//    rej[1:0]     one-cycle pulse: drop refused for player p
//    bomb_valid   per slot: slot is in FUSE or EXPL
//    bomb_expl    per slot: slot is in EXPL
//    expl_start   per slot: one-cycle pulse on FUSE -> EXPL
//    rd_idx       slot selected for read-back
//    rd_x/rd_y    coordinates of slot rd_idx (0 when out of range)
//    rd_owner     owner of slot rd_idx (0 when out of range)
// ============================================================================
module bomb_scheduler #(
    parameter int NB_BOMBS       = 4,
    parameter int FUSE_FRAMES    = 120,
    parameter int EXPL_FRAMES    = 30,
    parameter int TW             = 5,
    parameter int MAX_PER_PLAYER = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                EOF,
    input  logic [1:0]          req,
    input  logic [TW-1:0]       p0_x,
    input  logic [TW-1:0]       p0_y,
    input  logic [TW-1:0]       p1_x,
    input  logic [TW-1:0]       p1_y,
    output logic [1:0]          gnt,
    output logic [1:0]          rej,
    output logic [NB_BOMBS-1:0] bomb_valid,
    output logic [NB_BOMBS-1:0] bomb_expl,
    output logic [NB_BOMBS-1:0] expl_start,
    input  logic [2:0]          rd_idx,
    output logic [TW-1:0]       rd_x,
    output logic [TW-1:0]       rd_y,
    output logic                rd_owner
);

    localparam int MAX_FRAMES = (FUSE_FRAMES > EXPL_FRAMES) ? FUSE_FRAMES : EXPL_FRAMES;
    localparam int CW         = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam int SW         = $clog2(NB_BOMBS);

    localparam logic [CW-1:0] FUSE_LOAD = CW'(FUSE_FRAMES - 1);
    localparam logic [CW-1:0] EXPL_LOAD = CW'(EXPL_FRAMES - 1);

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_FUSE = 2'd1,
        SLOT_EXPL = 2'd2
    } slot_state_t;

    // Slot registers and their next values
    slot_state_t         slot_state_q [NB_BOMBS];
    slot_state_t         slot_state_d [NB_BOMBS];
    logic                slot_owner_q [NB_BOMBS];
    logic                slot_owner_d [NB_BOMBS];
    logic [TW-1:0]       slot_x_q     [NB_BOMBS];
    logic [TW-1:0]       slot_x_d     [NB_BOMBS];
    logic [TW-1:0]       slot_y_q     [NB_BOMBS];
    logic [TW-1:0]       slot_y_d     [NB_BOMBS];
    logic [CW-1:0]       slot_cnt_q   [NB_BOMBS];
    logic [CW-1:0]       slot_cnt_d   [NB_BOMBS];

    logic                eof_q;
    logic                rr_q;
    logic                rr_d;
    logic [1:0]          gnt_q;
    logic [1:0]          gnt_d;
    logic [1:0]          rej_q;
    logic [1:0]          rej_d;
    logic [NB_BOMBS-1:0] expl_start_q;
    logic [NB_BOMBS-1:0] expl_start_d;

    // Arbitration intermediates
    logic                tick;
    logic [TW-1:0]       req_x [2];
    logic [TW-1:0]       req_y [2];
    logic [1:0]          tile_busy;
    logic [1:0]          over_cap;
    logic [31:0]         active_cnt [2];
    logic                have_first;
    logic                have_second;
    logic [SW-1:0]       first_free;
    logic [SW-1:0]       second_free;
    logic                same_tile;
    logic                pri_req;
    logic                oth_req;
    logic                pri_ok;
    logic                oth_ok;
    logic [SW-1:0]       oth_slot;
    logic [TW-1:0]       pri_x;
    logic [TW-1:0]       pri_y;
    logic [TW-1:0]       oth_x;
    logic [TW-1:0]       oth_y;

    // A held-high EOF produces a single tick: only the 0->1 edge counts.
    assign tick = EOF & ~eof_q;

    // Player coordinates gathered into arrays so per-player logic can loop.
    always_comb begin
        req_x[0] = p0_x;
        req_y[0] = p0_y;
        req_x[1] = p1_x;
        req_y[1] = p1_y;
    end

    // A tile is busy for player p when any live slot (FUSE or EXPL) sits on
    // that player's tile. Uses pre-tick state, so a bomb expiring on this
    // very tick still blocks its tile for one more cycle.
    always_comb begin
        tile_busy = '0;
        for (int i = 0; i < NB_BOMBS; i++) begin
            if (slot_state_q[i] != SLOT_FREE) begin
                for (int p = 0; p < 2; p++) begin
                    if ((slot_x_q[i] == req_x[p]) && (slot_y_q[i] == req_y[p])) begin
                        tile_busy[p] = 1'b1;
                    end
                end
            end
        end
    end

    // The lowest and second-lowest FREE slots, taken from pre-tick state.
    // A slot freed by the current tick is only offered on the next cycle.
    always_comb begin
        have_first  = 1'b0;
        have_second = 1'b0;
        first_free  = '0;
        second_free = '0;
        for (int i = 0; i < NB_BOMBS; i++) begin
            if (slot_state_q[i] == SLOT_FREE) begin
                if (!have_first) begin
                    have_first = 1'b1;
                    first_free = SW'(i);
                end else if (!have_second) begin
                    have_second = 1'b1;
                    second_free = SW'(i);
                end
            end
        end
    end

`ifdef BOMB_LIMIT_EN
    // Live bombs owned by each player, counted straight from the slot states.
    always_comb begin
        active_cnt[0] = '0;
        active_cnt[1] = '0;
        for (int i = 0; i < NB_BOMBS; i++) begin
            if (slot_state_q[i] != SLOT_FREE) begin
                if (slot_owner_q[i]) begin
                    active_cnt[1] = active_cnt[1] + 32'd1;
                end else begin
                    active_cnt[0] = active_cnt[0] + 32'd1;
                end
            end
        end
    end
`else
    // Cap disabled: the count is tied to zero, so the cap compare below
    // folds to "never over the cap".
    always_comb begin
        active_cnt[0] = '0;
        active_cnt[1] = '0;
    end
`endif

    always_comb begin
        over_cap[0] = (active_cnt[0] >= 32'(MAX_PER_PLAYER));
        over_cap[1] = (active_cnt[1] >= 32'(MAX_PER_PLAYER));
    end

    // Arbitration. The rr player is served first and takes the lowest free
    // slot. The other player then takes the next free slot, or the lowest
    // one if the priority player was refused. A priority refusal never
    // blocks the other player. A shared tile only loses to a priority drop
    // that was actually granted.
    always_comb begin
        pri_req   = rr_q ? req[1] : req[0];
        oth_req   = rr_q ? req[0] : req[1];
        pri_x     = rr_q ? p1_x : p0_x;
        pri_y     = rr_q ? p1_y : p0_y;
        oth_x     = rr_q ? p0_x : p1_x;
        oth_y     = rr_q ? p0_y : p1_y;
        same_tile = (p0_x == p1_x) && (p0_y == p1_y);

        pri_ok = pri_req
               & ~(rr_q ? tile_busy[1] : tile_busy[0])
               & ~(rr_q ? over_cap[1]  : over_cap[0])
               & have_first;

        oth_ok = oth_req
               & ~(rr_q ? tile_busy[0] : tile_busy[1])
               & ~(rr_q ? over_cap[0]  : over_cap[1])
               & ~(pri_ok & same_tile)
               & (pri_ok ? have_second : have_first);

        oth_slot = pri_ok ? second_free : first_free;
    end

    // Next-state logic for the grant pulses, the rr pointer and every slot
    // FSM. Allocation only ever targets FREE slots. Because of that, a slot
    // allocated this cycle is never also decremented by a coincident tick.
    always_comb begin
        rr_d = rr_q;
        if (req == 2'b11) begin
            rr_d = ~rr_q;
        end

        gnt_d = rr_q ? {pri_ok, oth_ok} : {oth_ok, pri_ok};
        rej_d = rr_q ? {pri_req & ~pri_ok, oth_req & ~oth_ok}
                     : {oth_req & ~oth_ok, pri_req & ~pri_ok};

        expl_start_d = '0;

        for (int i = 0; i < NB_BOMBS; i++) begin
            slot_state_d[i] = slot_state_q[i];
            slot_owner_d[i] = slot_owner_q[i];
            slot_x_d[i]     = slot_x_q[i];
            slot_y_d[i]     = slot_y_q[i];
            slot_cnt_d[i]   = slot_cnt_q[i];

            case (slot_state_q[i])
                SLOT_FREE: begin
                    if (pri_ok && (first_free == SW'(i))) begin
                        slot_state_d[i] = SLOT_FUSE;
                        slot_owner_d[i] = rr_q;
                        slot_x_d[i]     = pri_x;
                        slot_y_d[i]     = pri_y;
                        slot_cnt_d[i]   = FUSE_LOAD;
                    end else if (oth_ok && (oth_slot == SW'(i))) begin
                        slot_state_d[i] = SLOT_FUSE;
                        slot_owner_d[i] = ~rr_q;
                        slot_x_d[i]     = oth_x;
                        slot_y_d[i]     = oth_y;
                        slot_cnt_d[i]   = FUSE_LOAD;
                    end
                end
                SLOT_FUSE: begin
                    if (tick) begin
                        if (slot_cnt_q[i] != '0) begin
                            slot_cnt_d[i] = slot_cnt_q[i] - 1'b1;
                        end else begin
                            slot_state_d[i] = SLOT_EXPL;
                            slot_cnt_d[i]   = EXPL_LOAD;
                            expl_start_d[i] = 1'b1;
                        end
                    end
                end
                SLOT_EXPL: begin
                    if (tick) begin
                        if (slot_cnt_q[i] != '0) begin
                            slot_cnt_d[i] = slot_cnt_q[i] - 1'b1;
                        end else begin
                            slot_state_d[i] = SLOT_FREE;
                        end
                    end
                end
                default: begin
                    slot_state_d[i] = SLOT_FREE;
                end
            endcase
        end
    end

    // State register. Reset aborts every bomb and clears all pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eof_q        <= 1'b0;
            rr_q         <= 1'b0;
            gnt_q        <= '0;
            rej_q        <= '0;
            expl_start_q <= '0;
            for (int i = 0; i < NB_BOMBS; i++) begin
                slot_state_q[i] <= SLOT_FREE;
                slot_owner_q[i] <= 1'b0;
                slot_x_q[i]     <= '0;
                slot_y_q[i]     <= '0;
                slot_cnt_q[i]   <= '0;
            end
        end else begin
            eof_q        <= EOF;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            rej_q        <= rej_d;
            expl_start_q <= expl_start_d;
            for (int i = 0; i < NB_BOMBS; i++) begin
                slot_state_q[i] <= slot_state_d[i];
                slot_owner_q[i] <= slot_owner_d[i];
                slot_x_q[i]     <= slot_x_d[i];
                slot_y_q[i]     <= slot_y_d[i];
                slot_cnt_q[i]   <= slot_cnt_d[i];
            end
        end
    end

    // Outputs. Slot status and read-back come straight from the slot
    // registers. An out-of-range read-back index reads as zero.
    always_comb begin
        gnt        = gnt_q;
        rej        = rej_q;
        expl_start = expl_start_q;
        for (int i = 0; i < NB_BOMBS; i++) begin
            bomb_valid[i] = (slot_state_q[i] != SLOT_FREE);
            bomb_expl[i]  = (slot_state_q[i] == SLOT_EXPL);
        end

        rd_x     = '0;
        rd_y     = '0;
        rd_owner = 1'b0;
        if ({29'd0, rd_idx} < 32'(NB_BOMBS)) begin
            rd_x     = slot_x_q[rd_idx[SW-1:0]];
            rd_y     = slot_y_q[rd_idx[SW-1:0]];
            rd_owner = slot_owner_q[rd_idx[SW-1:0]];
        end
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// ============================================================================
// tb_bomb_scheduler
// ----------------------------------------------------------------------------
// Self-checking bench for bomb_scheduler.
//
// The reference model tracks each bomb as a single "frames of life left"
// number. It starts at FUSE+EXPL and drops by one per frame tick. The bomb is
// in EXPL while life <= EXPL and is gone at life 0. Drop decisions follow the
// pool rules directly: the priority player first, then the other player.
// ============================================================================
`timescale 1ns/1ps
module tb_bomb_scheduler;

    localparam int NB   = 4;
    localparam int FUSE = 120;
    localparam int EXPL = 30;
    localparam int TW   = 5;
    localparam int MAXP = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          EOF;
    logic [1:0]    req;
    logic [TW-1:0] p0_x, p0_y, p1_x, p1_y;
    logic [1:0]    gnt, rej;
    logic [NB-1:0] bomb_valid, bomb_expl, expl_start;
    logic [2:0]    rd_idx;
    logic [TW-1:0] rd_x, rd_y;
    logic          rd_owner;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            life [NB];
    bit            own  [NB];
    logic [TW-1:0] mx   [NB];
    logic [TW-1:0] my   [NB];
    bit            m_rr;
    bit            m_eof_q;
    logic [1:0]    exp_gnt;
    logic [1:0]    exp_rej;
    logic [NB-1:0] exp_start;

    bomb_scheduler #(
        .NB_BOMBS(NB), .FUSE_FRAMES(FUSE), .EXPL_FRAMES(EXPL),
        .TW(TW), .MAX_PER_PLAYER(MAXP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .EOF(EOF), .req(req),
        .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
        .gnt(gnt), .rej(rej),
        .bomb_valid(bomb_valid), .bomb_expl(bomb_expl), .expl_start(expl_start),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_owner(rd_owner)
    );

    // 20 ns clock
    always #10 clk = ~clk;

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NB; i++) begin
            life[i] = 0;
            own[i]  = 1'b0;
            mx[i]   = '0;
            my[i]   = '0;
        end
        m_rr      = 1'b0;
        m_eof_q   = 1'b0;
        exp_gnt   = '0;
        exp_rej   = '0;
        exp_start = '0;
    endtask

    // One clock of the reference model, fed with the inputs seen at the edge.
    task automatic modelStep(input logic [1:0] r, input logic [TW-1:0] x0, input logic [TW-1:0] y0,
                             input logic [TW-1:0] x1, input logic [TW-1:0] y1, input logic e);
        bit            tk;
        int            freeq[$];
        int            new_slot [2];
        logic [TW-1:0] px [2];
        logic [TW-1:0] py [2];
        bit            refuse;
        int            p;
`ifdef BOMB_LIMIT_EN
        int            cnt;
`endif
        px[0] = x0; py[0] = y0; px[1] = x1; py[1] = y1;
        tk = e && !m_eof_q;
        m_eof_q = e;
        exp_gnt = '0;
        exp_rej = '0;
        exp_start = '0;
        new_slot[0] = -1;
        new_slot[1] = -1;
        for (int i = 0; i < NB; i++) if (life[i] == 0) freeq.push_back(i);

        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? int'(m_rr) : int'(!m_rr);
            if (r[p]) begin
                refuse = 1'b0;
                for (int i = 0; i < NB; i++)
                    if (life[i] > 0 && mx[i] == px[p] && my[i] == py[p]) refuse = 1'b1;
                if (k == 1 && exp_gnt[1-p] && px[0] == px[1] && py[0] == py[1]) refuse = 1'b1;
`ifdef BOMB_LIMIT_EN
                cnt = 0;
                for (int i = 0; i < NB; i++) if (life[i] > 0 && own[i] == p[0]) cnt++;
                if (cnt >= MAXP) refuse = 1'b1;
`endif
                if (freeq.size() == 0) refuse = 1'b1;
                if (refuse) begin
                    exp_rej[p] = 1'b1;
                end else begin
                    exp_gnt[p] = 1'b1;
                    new_slot[p] = freeq.pop_front();
                end
            end
        end

        if (tk) begin
            for (int i = 0; i < NB; i++) begin
                if (life[i] > 0) begin
                    life[i]--;
                    if (life[i] == EXPL) exp_start[i] = 1'b1;
                end
            end
        end

        for (int q = 0; q < 2; q++) begin
            if (new_slot[q] >= 0) begin
                life[new_slot[q]] = FUSE + EXPL;
                own[new_slot[q]]  = q[0];
                mx[new_slot[q]]   = px[q];
                my[new_slot[q]]   = py[q];
            end
        end

        if (r == 2'b11) m_rr = !m_rr;
    endtask

    task automatic checkOutput();
        logic [NB-1:0] ev, ee;
        for (int i = 0; i < NB; i++) begin
            ev[i] = (life[i] > 0);
            ee[i] = (life[i] > 0) && (life[i] <= EXPL);
        end
        check1("gnt", 32'(gnt), 32'(exp_gnt));
        check1("rej", 32'(rej), 32'(exp_rej));
        check1("bomb_valid", 32'(bomb_valid), 32'(ev));
        check1("bomb_expl", 32'(bomb_expl), 32'(ee));
        check1("expl_start", 32'(expl_start), 32'(exp_start));
    endtask

    // Read back every index, including the out-of-range ones. Free slots are
    // skipped because their stale contents carry no meaning.
    task automatic checkReadback();
        for (int idx = 0; idx < 8; idx++) begin
            rd_idx = 3'(idx);
            #1;
            if (idx >= NB) begin
                check1("rd_oob", {rd_owner, rd_x, rd_y}, 32'd0);
            end else if (life[idx] > 0) begin
                check1("rd_slot", {rd_owner, rd_x, rd_y}, {own[idx], mx[idx], my[idx]});
            end
        end
        rd_idx = 3'd0;
    endtask

    // Drive one cycle of inputs, step the model, and check one ns after the edge.
    task automatic applyStimulus(input logic [1:0] r, input logic [TW-1:0] x0, input logic [TW-1:0] y0,
                                 input logic [TW-1:0] x1, input logic [TW-1:0] y1, input logic e);
        req = r; p0_x = x0; p0_y = y0; p1_x = x1; p1_y = y1; EOF = e;
        modelStep(r, x0, y0, x1, y1, e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
            applyStimulus(2'b00, '0, '0, '0, '0, 1'b0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        EOF = 1'b0; req = 2'b00;
        p0_x = '0; p0_y = '0; p1_x = '0; p1_y = '0;
        rd_idx = 3'd0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        reset_n = 1'b1;

        // Single drop and full fuse/explosion life cycle
        $display("[TB] single drop life cycle");
        applyStimulus(2'b01, 5'd3, 5'd4, '0, '0, 1'b0);
        check1("t1_gnt", 32'(gnt), 32'd1);
        checkReadback();
        frames(119);
        check1("t1_fuse_valid", 32'(bomb_valid), 32'd1);
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        check1("t1_expl_start", 32'(expl_start), 32'd1);
        check1("t1_bomb_expl", 32'(bomb_expl), 32'd1);
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b0);
        frames(29);
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        check1("t1_freed", 32'(bomb_valid), 32'd0);
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b0);

        // Simultaneous drops on distinct tiles, rr = 0
        $display("[TB] simultaneous distinct tiles");
        applyStimulus(2'b11, 5'd2, 5'd2, 5'd5, 5'd5, 1'b0);
        check1("t2_gnt", 32'(gnt), 32'd3);
        rd_idx = 3'd1; #1;
        check1("t2_slot1_owner", 32'(rd_owner), 32'd1);
        checkReadback();
        frames(150);

        // Simultaneous drops on the same tile, rr = 1
        $display("[TB] simultaneous same tile");
        applyStimulus(2'b11, 5'd7, 5'd7, 5'd7, 5'd7, 1'b0);
        check1("t3_gnt", 32'(gnt), 32'd2);
        check1("t3_rej", 32'(rej), 32'd1);
        rd_idx = 3'd0; #1;
        check1("t3_slot0_owner", 32'(rd_owner), 32'd1);
        checkReadback();
        frames(150);

        // Pool exhaustion, then a drop on a tile that is exploding
        $display("[TB] pool full and occupied tile");
        applyStimulus(2'b01, 5'd1, 5'd1, '0, '0, 1'b0);
        applyStimulus(2'b10, '0, '0, 5'd1, 5'd2, 1'b0);
        applyStimulus(2'b01, 5'd1, 5'd3, '0, '0, 1'b0);
        applyStimulus(2'b10, '0, '0, 5'd1, 5'd4, 1'b0);
        applyStimulus(2'b01, 5'd9, 5'd9, '0, '0, 1'b0);
        check1("t4_full_rej", 32'(rej), 32'd1);
        check1("t4_full_valid", 32'(bomb_valid), 32'hF);
        frames(150);
        applyStimulus(2'b01, 5'd6, 5'd6, '0, '0, 1'b0);
        frames(121);
        applyStimulus(2'b10, '0, '0, 5'd6, 5'd6, 1'b0);
        check1("t4_expl_tile_rej", 32'(rej), 32'd2);
        frames(40);

        // Tick coincident with a request while slot 0 finishes exploding
        $display("[TB] tick coincident with allocation");
        applyStimulus(2'b01, 5'd8, 5'd1, '0, '0, 1'b0);
        frames(149);
        applyStimulus(2'b01, 5'd8, 5'd2, '0, '0, 1'b1);
        check1("t5_gnt", 32'(gnt), 32'd1);
        check1("t5_valid", 32'(bomb_valid), 32'd2);
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b0);
        checkReadback();
        frames(150);

        // Per-player cap (active only with BOMB_LIMIT_EN)
        $display("[TB] per-player drops");
        applyStimulus(2'b01, 5'd10, 5'd1, '0, '0, 1'b0);
        applyStimulus(2'b01, 5'd10, 5'd2, '0, '0, 1'b0);
        applyStimulus(2'b01, 5'd10, 5'd3, '0, '0, 1'b0);
`ifdef BOMB_LIMIT_EN
        check1("t6_third_rej", 32'(rej), 32'd1);
`else
        check1("t6_third_gnt", 32'(gnt), 32'd1);
`endif
        applyStimulus(2'b10, '0, '0, 5'd10, 5'd4, 1'b0);
        check1("t6_p1_gnt", 32'(gnt), 32'd2);
        frames(150);

        // Held request: granted once, then refused on its own tile
        $display("[TB] held request and held EOF");
        applyStimulus(2'b01, 5'd12, 5'd12, '0, '0, 1'b0);
        check1("held_gnt", 32'(gnt), 32'd1);
        applyStimulus(2'b01, 5'd12, 5'd12, '0, '0, 1'b0);
        check1("held_rej1", 32'(rej), 32'd1);
        applyStimulus(2'b01, 5'd12, 5'd12, '0, '0, 1'b0);
        check1("held_rej2", 32'(rej), 32'd1);
        for (int c = 0; c < 5; c++) applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
        applyStimulus(2'b00, '0, '0, '0, '0, 1'b0);
        frames(150);

        // Randomised traffic on a small tile range to provoke collisions
        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(2'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
            if ((c % 50) == 0) checkReadback();
        end
        frames(150);

        // Asynchronous reset in the middle of a fuse
        $display("[TB] reset mid-fuse");
        applyStimulus(2'b01, 5'd2, 5'd3, '0, '0, 1'b0);
        frames(50);
        req = 2'b00; EOF = 1'b0;
        #4;
        reset_n = 1'b0;
        #1;
        modelReset();
        check1("rst_gnt", 32'(gnt), 32'd0);
        check1("rst_rej", 32'(rej), 32'd0);
        check1("rst_valid", 32'(bomb_valid), 32'd0);
        check1("rst_expl", 32'(bomb_expl), 32'd0);
        check1("rst_start", 32'(expl_start), 32'd0);
        check1("rst_rd", {rd_owner, rd_x, rd_y}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        frames(125);
        check1("rst_no_bomb", 32'(bomb_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
